// File: rtl/i2c_target.sv
// i2c_target: open-drain I2C target with an NREGS x 8-bit register file.
// Bus transactions: 7-bit address, register subaddress, then auto-incrementing
// data bytes. A host port gives firmware read/write access to the same registers.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NREGS    = 16,
  parameter int         FILT     = 4,
  localparam int        PW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          busy,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_index
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_SUB, S_SACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  // ---------------------------------------------------------------------
  // Input conditioning: bit 0 = SCL, bit 1 = SDA
  // ---------------------------------------------------------------------
  logic [1:0] pad_in;
  logic [1:0] filt;
  logic [1:0] filt_prev;

  assign pad_in = {sda_in, scl_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cond
    logic          meta;
    logic          sync;
    logic          lvl;
    logic          lvl_prev;
    logic [CW-1:0] cnt;

    // Synchronise the pad, then accept a new level only after FILT matching samples
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        meta     <= 1'b1;
        sync     <= 1'b1;
        lvl      <= 1'b1;
        lvl_prev <= 1'b1;
        cnt      <= '0;
      end else begin
        meta     <= pad_in[gi];
        sync     <= meta;
        lvl_prev <= lvl;
        if (sync == lvl) begin
          cnt <= '0;
        end else if (cnt == CW'(FILT - 1)) begin
          lvl <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign filt[gi]      = lvl;
    assign filt_prev[gi] = lvl_prev;
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_p    = filt_prev[0];
  assign sda_p    = filt_prev[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & sda_p & ~sda_f;
  assign stop_c   = scl_f & ~sda_p & sda_f;

  // ---------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------
  state_t        state, state_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shreg, shreg_next;
  logic          rw, rw_next;
  logic [PW-1:0] ptr, ptr_next;
  logic          busy_next;
  logic          sda_oe_next;
  logic          wr_pulse_next;
  logic [PW-1:0] wr_index_next;
  logic          bus_we;
  logic [7:0]    byte_in;

  logic [7:0]    regs [NREGS];

  // Byte completed by the current SCL rise (seven shifted bits plus live SDA)
  assign byte_in = {shreg[6:0], sda_f};

  // Protocol state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      busy     <= 1'b0;
      sda_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      wr_index <= '0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      shreg    <= shreg_next;
      rw       <= rw_next;
      ptr      <= ptr_next;
      busy     <= busy_next;
      sda_oe   <= sda_oe_next;
      wr_pulse <= wr_pulse_next;
      wr_index <= wr_index_next;
    end
  end

  // Next-state logic; bus START/STOP override any SCL edge in the same cycle
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    shreg_next    = shreg;
    rw_next       = rw;
    ptr_next      = ptr;
    busy_next     = busy;
    sda_oe_next   = sda_oe;
    wr_pulse_next = 1'b0;
    wr_index_next = wr_index;
    bus_we        = 1'b0;

    if (stop_c) begin
      state_next   = S_IDLE;
      sda_oe_next  = 1'b0;
      bit_cnt_next = '0;
      busy_next    = 1'b0;
    end else if (start_c) begin
      state_next   = S_ADDR;
      sda_oe_next  = 1'b0;
      bit_cnt_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_ADDR, S_SUB, S_WDATA: begin
          if (scl_rise) begin
            shreg_next   = byte_in;
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_next = '0;
              if (state == S_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  rw_next    = byte_in[0];
                  busy_next  = 1'b1;
                  state_next = S_AACK;
                end else begin
                  state_next = S_IGNORE;
                end
              end else if (state == S_SUB) begin
                ptr_next   = byte_in[PW-1:0];
                state_next = S_SACK;
              end else begin
                bus_we        = 1'b1;
                wr_pulse_next = 1'b1;
                wr_index_next = ptr;
                ptr_next      = ptr + 1'b1;
                state_next    = S_WACK;
              end
            end
          end
        end

        // First fall pulls SDA for the ACK slot, second fall releases it
        S_AACK, S_SACK, S_WACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next = 1'b0;
              if (state == S_AACK && rw) begin
                shreg_next   = regs[ptr];
                sda_oe_next  = ~regs[ptr][7];
                bit_cnt_next = '0;
                state_next   = S_RDATA;
              end else if (state == S_AACK) begin
                state_next = S_SUB;
              end else begin
                state_next = S_WDATA;
              end
            end
          end
        end

        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_next = 1'b0;
              state_next  = S_RACK;
            end else begin
              shreg_next  = {shreg[6:0], 1'b0};
              sda_oe_next = ~shreg[6];
            end
          end
        end

        // bit_cnt = 9 marks "controller ACKed, load next byte on the fall"
        S_RACK: begin
          if (scl_rise) begin
            ptr_next = ptr + 1'b1;
            if (!sda_f) begin
              bit_cnt_next = 4'd9;
            end else begin
              state_next = S_IGNORE;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            shreg_next   = regs[ptr];
            sda_oe_next  = ~regs[ptr][7];
            bit_cnt_next = '0;
            state_next   = S_RDATA;
          end
        end

        S_IGNORE: begin
          sda_oe_next = 1'b0;
        end

        default: begin
          state_next  = S_IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  // Register file: a bus write beats a host write to the same index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus_we && ptr == PW'(i)) begin
          regs[i] <= byte_in;
        end else if (host_we && host_addr == PW'(i)) begin
          regs[i] <= host_wdata;
        end
      end
    end
  end

  // Host read port, one cycle of latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      host_rdata <= '0;
    end else begin
      host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller with a wired-AND SDA line,
// register-file reference model, randomized data and subaddresses.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h42;
  localparam int         NR  = 16;
  localparam int         H   = 16;   // half SCL period in clk
  localparam int         Q   = 4;    // SDA setup delay after SCL fall
  localparam logic [7:0] AW  = {DEV, 1'b0};
  localparam logic [7:0] AR  = {DEV, 1'b1};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       scl_in, sda_in, sda_oe, busy, wr_pulse;
  logic [3:0] wr_index;
  logic [7:0] host_rdata;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(DEV), .NREGS(NR), .FILT(4)) dut (
    .clk(clk), .resetn(resetn), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .busy(busy), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [7:0] mregs [NR];
  int         mptr;
  logic [3:0] ewl [$];

  // Transaction buffers
  logic [7:0] tx   [8];
  logic [7:0] rbuf [8];
  logic       roe  [8];

  // Monitors
  int         oe_cnt = 0;
  int         busy_cnt = 0;
  logic [3:0] wlog [$];

  always @(negedge clk) begin
    if (sda_oe)   oe_cnt++;
    if (busy)     busy_cnt++;
    if (wr_pulse) wlog.push_back(wr_index);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus / host primitives ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    tick(Q); sda_drv = 1'b1; tick(H - Q); scl_drv = 1'b1; tick(H);
    sda_drv = 1'b0; tick(H); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_drv = 1'b0; tick(H - Q); scl_drv = 1'b1; tick(H);
    sda_drv = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); sda_drv = b; tick(H - Q); scl_drv = 1'b1; tick(H); scl_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(Q); sda_drv = 1'b1; tick(H - Q); scl_drv = 1'b1; tick(H / 2);
    ack = (sda_in == 1'b0);
    tick(H / 2); scl_drv = 1'b0;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] b, output logic oe9);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); sda_drv = 1'b1; tick(H - Q); scl_drv = 1'b1; tick(H / 2);
      b[i] = sda_in;
      tick(H / 2); scl_drv = 1'b0;
    end
    tick(Q); sda_drv = ~give_ack; tick(H - Q); scl_drv = 1'b1; tick(H / 2);
    oe9 = sda_oe;
    tick(H / 2); scl_drv = 1'b0;
  endtask

  task automatic bus_write_txn(input logic [7:0] addrb, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    write_byte(addrb, a); acks += int'(a);
    for (int k = 0; k < n; k++) begin
      write_byte(tx[k], a); acks += int'(a);
    end
    bus_stop();
    tick(12);
  endtask

  task automatic bus_read_txn(input bit set_sub, input logic [7:0] sub, input int n,
                              output int acks);
    logic a;
    acks = 0;
    bus_start();
    if (set_sub) begin
      write_byte(AW, a);  acks += int'(a);
      write_byte(sub, a); acks += int'(a);
      bus_start();
    end
    write_byte(AR, a); acks += int'(a);
    for (int k = 0; k < n; k++) read_byte(k != n - 1, rbuf[k], roe[k]);
    bus_stop();
    tick(12);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1; tick(1); host_we = 1'b0;
    mregs[a] = d;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a; tick(2); d = host_rdata;
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
  endtask

  task automatic model_write(input logic [7:0] addrb, input int n);
    ewl.delete();
    if (addrb[7:1] == DEV && !addrb[0] && n > 0) begin
      mptr = int'(tx[0]) % NR;
      for (int k = 1; k < n; k++) begin
        mregs[mptr] = tx[k];
        ewl.push_back(4'(mptr));
        mptr = (mptr + 1) % NR;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; tick(4);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (wr_pulse !== 1'b0) begin fails++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
    tests++; if (wr_index !== 4'h0) begin fails++; $display("FAIL reset_wr_index: got %h expected 0", wr_index); end
    tests++; if (host_rdata !== 8'h00) begin fails++; $display("FAIL reset_host_rdata: got %h expected 00", host_rdata); end
    resetn = 1'b1; tick(10);
    model_reset();
    $display("[TB] reset checked");
  endtask

  task automatic test_write();
    int acks, n0, b0, n;
    logic [7:0] d;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        tx[0] = 8'h03; tx[1] = 8'hA5; tx[2] = 8'h5A; n = 3;
      end else begin
        n = $urandom_range(2, 4);
        for (int k = 0; k < n; k++) tx[k] = 8'($urandom);
      end
      n0 = wlog.size(); b0 = busy_cnt;
      bus_write_txn(AW, n, acks);
      model_write(AW, n);
      tests++; if (acks != n + 1) begin fails++; $display("FAIL write_acks: got %0d expected %0d", acks, n + 1); end
      tests++; if (wlog.size() - n0 != ewl.size()) begin fails++; $display("FAIL write_pulse_count: got %0d expected %0d", wlog.size() - n0, ewl.size()); end
      for (int k = 0; k < ewl.size() && n0 + k < wlog.size(); k++) begin
        tests++; if (wlog[n0 + k] !== ewl[k]) begin fails++; $display("FAIL write_wr_index: got %h expected %h", wlog[n0 + k], ewl[k]); end
      end
      tests++; if (busy_cnt == b0) begin fails++; $display("FAIL write_busy_seen: got 0 expected 1"); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
      for (int i = 0; i < NR; i++) begin
        host_read(4'(i), d);
        tests++; if (d !== mregs[i]) begin fails++; $display("FAIL write_reg[%0d]: got %h expected %h", i, d, mregs[i]); end
      end
      $display("[TB] write txn sub=%h bytes=%0d acks=%0d", tx[0], n - 1, acks);
    end
  endtask

  task automatic test_read();
    int acks, n;
    logic [7:0] sub, e;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        sub = 8'h03; n = 2;
      end else begin
        sub = 8'($urandom); n = $urandom_range(1, 4);
      end
      bus_read_txn(r != 3, sub, n, acks);
      if (r != 3) mptr = int'(sub) % NR;
      tests++; if (acks != ((r != 3) ? 3 : 1)) begin fails++; $display("FAIL read_acks: got %0d expected %0d", acks, (r != 3) ? 3 : 1); end
      for (int k = 0; k < n; k++) begin
        e = mregs[mptr];
        mptr = (mptr + 1) % NR;
        tests++; if (rbuf[k] !== e) begin fails++; $display("FAIL read_data[%0d]: got %h expected %h", k, rbuf[k], e); end
        tests++; if (roe[k] !== 1'b0) begin fails++; $display("FAIL read_oe_9th[%0d]: got %b expected 0", k, roe[k]); end
      end
      $display("[TB] read txn sub=%h bytes=%0d first=%h", sub, n, rbuf[0]);
    end
  endtask

  task automatic test_miss();
    int acks, o0, b0, w0;
    logic [7:0] addrb, d;
    logic [6:0] a7;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        addrb = 8'h90;
      end else begin
        do a7 = 7'($urandom_range(0, 127)); while (a7 == DEV);
        addrb = {a7, 1'($urandom)};
      end
      tx[0] = 8'h03; tx[1] = 8'h11;
      o0 = oe_cnt; b0 = busy_cnt; w0 = wlog.size();
      bus_write_txn(addrb, 2, acks);
      tests++; if (acks != 0) begin fails++; $display("FAIL miss_acks: got %0d expected 0", acks); end
      tests++; if (oe_cnt != o0) begin fails++; $display("FAIL miss_sda_oe: got %0d cycles expected 0", oe_cnt - o0); end
      tests++; if (busy_cnt != b0) begin fails++; $display("FAIL miss_busy: got %0d cycles expected 0", busy_cnt - b0); end
      tests++; if (wlog.size() != w0) begin fails++; $display("FAIL miss_wr_pulse: got %0d expected 0", wlog.size() - w0); end
      host_read(4'h3, d);
      tests++; if (d !== mregs[3]) begin fails++; $display("FAIL miss_reg3: got %h expected %h", d, mregs[3]); end
      $display("[TB] miss txn addr=%h acks=%0d", addrb, acks);
    end
  endtask

  task automatic test_wrap();
    int acks, n0;
    logic [7:0] d;
    host_write(4'h1, 8'($urandom) | 8'h01);
    tx[0] = 8'h0F; tx[1] = 8'h11; tx[2] = 8'h22;
    n0 = wlog.size();
    bus_write_txn(AW, 3, acks);
    model_write(AW, 3);
    tests++; if (acks != 4) begin fails++; $display("FAIL wrap_acks: got %0d expected 4", acks); end
    tests++; if (wlog.size() - n0 != 2) begin fails++; $display("FAIL wrap_pulse_count: got %0d expected 2", wlog.size() - n0); end
    for (int k = 0; k < 2 && n0 + k < wlog.size(); k++) begin
      tests++; if (wlog[n0 + k] !== ewl[k]) begin fails++; $display("FAIL wrap_wr_index: got %h expected %h", wlog[n0 + k], ewl[k]); end
    end
    host_read(4'hF, d);
    tests++; if (d !== mregs[15]) begin fails++; $display("FAIL wrap_reg15: got %h expected %h", d, mregs[15]); end
    host_read(4'h0, d);
    tests++; if (d !== mregs[0]) begin fails++; $display("FAIL wrap_reg0: got %h expected %h", d, mregs[0]); end
    bus_read_txn(1'b0, 8'h00, 1, acks);
    tests++; if (rbuf[0] !== mregs[mptr]) begin fails++; $display("FAIL wrap_read_ptr: got %h expected %h", rbuf[0], mregs[mptr]); end
    mptr = (mptr + 1) % NR;
    $display("[TB] wrap txn read=%h", rbuf[0]);
  endtask

  task automatic test_abort();
    logic a1, a2, a3, a4, a5;
    logic [7:0] d, s, v;
    int w0;
    host_write(4'h2, 8'($urandom));
    w0 = wlog.size();
    bus_start(); write_byte(AW, a1); write_byte(8'h02, a2);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop(); tick(12);
    mptr = 2;
    tests++; if ({a1, a2} !== 2'b11) begin fails++; $display("FAIL abort_stop_acks: got %b expected 11", {a1, a2}); end
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL abort_stop_sda_oe: got %b expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_stop_busy: got %b expected 0", busy); end
    tests++; if (wlog.size() != w0) begin fails++; $display("FAIL abort_stop_wr_pulse: got %0d expected 0", wlog.size() - w0); end
    host_read(4'h2, d);
    tests++; if (d !== mregs[2]) begin fails++; $display("FAIL abort_stop_reg2: got %h expected %h", d, mregs[2]); end
    $display("[TB] abort by STOP reg2=%h", d);

    s = 8'($urandom_range(3, 15)); v = 8'($urandom);
    bus_start(); write_byte(AW, a1); write_byte(8'h02, a2);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_start(); write_byte(AW, a3); write_byte(s, a4); write_byte(v, a5);
    bus_stop(); tick(12);
    mptr = int'(s); mregs[mptr] = v; mptr = (mptr + 1) % NR;
    tests++; if ({a1, a2, a3, a4, a5} !== 5'b11111) begin fails++; $display("FAIL abort_start_acks: got %b expected 11111", {a1, a2, a3, a4, a5}); end
    host_read(4'h2, d);
    tests++; if (d !== mregs[2]) begin fails++; $display("FAIL abort_start_reg2: got %h expected %h", d, mregs[2]); end
    host_read(s[3:0], d);
    tests++; if (d !== v) begin fails++; $display("FAIL abort_start_new_write: got %h expected %h", d, v); end
    $display("[TB] abort by START then write reg%0d=%h", s, v);
  endtask

  task automatic test_collision();
    int acks;
    bit seen;
    logic [3:0] bidx, hidx;
    logic [7:0] bv, hv, d;
    for (int r = 0; r < 2; r++) begin
      bidx = 4'($urandom_range(0, 15)); bv = 8'($urandom); hv = ~bv;
      hidx = (r == 0) ? bidx : bidx + 4'd5;
      tx[0] = {4'h0, bidx}; tx[1] = bv; seen = 1'b0;
      fork
        bus_write_txn(AW, 2, acks);
        begin
          host_addr = hidx; host_wdata = hv; host_we = 1'b1;
          for (int c = 0; c < 4000 && !seen; c++) begin
            tick(1);
            if (wr_pulse) seen = 1'b1;
          end
          host_we = 1'b0;
        end
      join
      mregs[hidx] = hv;
      model_write(AW, 2);
      tests++; if (!seen) begin fails++; $display("FAIL collide_wr_pulse_timeout: got none expected 1"); end
      tests++; if (acks != 3) begin fails++; $display("FAIL collide_acks: got %0d expected 3", acks); end
      host_read(bidx, d);
      tests++; if (d !== mregs[bidx]) begin fails++; $display("FAIL collide_bus_reg: got %h expected %h", d, mregs[bidx]); end
      host_read(hidx, d);
      tests++; if (d !== mregs[hidx]) begin fails++; $display("FAIL collide_host_reg: got %h expected %h", d, mregs[hidx]); end
      $display("[TB] collision bus_idx=%h host_idx=%h result=%h", bidx, hidx, mregs[bidx]);
    end
  endtask

  task automatic test_reset_midread();
    logic a1, a2, a3;
    logic [7:0] d;
    int acks;
    host_write(4'h7, 8'h3C);
    host_write(4'h9, 8'($urandom) | 8'h80);
    bus_start(); write_byte(AW, a1); write_byte(8'h07, a2);
    bus_start(); write_byte(AR, a3);
    tick(H - Q);
    tests++; if ({a1, a2, a3} !== 3'b111) begin fails++; $display("FAIL rstmid_acks: got %b expected 111", {a1, a2, a3}); end
    tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rstmid_driving: got %b expected 1", sda_oe); end
    #2 resetn = 1'b0;
    #1;
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rstmid_async_sda_oe: got %b expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tick(2); scl_drv = 1'b1; tick(H); sda_drv = 1'b1; tick(H);
    resetn = 1'b1; tick(12);
    model_reset();
    host_read(4'h7, d);
    tests++; if (d !== mregs[7]) begin fails++; $display("FAIL rstmid_reg7: got %h expected %h", d, mregs[7]); end
    host_read(4'h9, d);
    tests++; if (d !== mregs[9]) begin fails++; $display("FAIL rstmid_reg9: got %h expected %h", d, mregs[9]); end
    tx[0] = 8'h05; tx[1] = 8'($urandom);
    bus_write_txn(AW, 2, acks);
    model_write(AW, 2);
    tests++; if (acks != 3) begin fails++; $display("FAIL rstmid_next_acks: got %0d expected 3", acks); end
    host_read(4'h5, d);
    tests++; if (d !== mregs[5]) begin fails++; $display("FAIL rstmid_next_reg5: got %h expected %h", d, mregs[5]); end
    $display("[TB] reset mid-read, then write reg5=%h", d);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_miss();
    test_wrap();
    test_abort();
    test_collision();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
